// File: rtl/ssm_master_ifc_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ssm_master_ifc_driver : FIFO-buffered command issuer for a master_ifc slave |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ssm_master_ifc_driver #(
  parameter int ADDR_W  = 1,
  parameter int DATA_W  = 1,
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_address_i,
  input  logic [DATA_W-1:0] cmd_write_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_read_data_o,
  output logic              rsp_error_o,
  output logic              rsp_timeout_o,
  output logic [ADDR_W-1:0] master_ifc_address_o,
  output logic [DATA_W-1:0] master_ifc_write_data_o,
  output logic              master_ifc_read_o,
  output logic              master_ifc_write_o,
  input  logic [DATA_W-1:0] master_ifc_read_data_i,
  input  logic              master_ifc_ready_i,
  input  logic              master_ifc_error_i,
  output logic              busy_o,
  output logic              spurious_ready_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PTR_W = FIFO_AW + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]  head;
  logic              fifo_empty, fifo_full, push, pop;

  logic              rsp_valid_q, rsp_error_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_read_data_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] write_data_q;
  logic              read_q, write_q, spurious_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  // The head leaves the FIFO exactly when the FSM launches it into REQ.
  assign pop         = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_RSP) && rsp_ready_i));
  assign cmd_ready_o = !fifo_full || pop;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {cmd_write_i, cmd_address_i, cmd_write_data_i};
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_error_q     <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      rsp_read_data_q <= '0;
      address_q       <= '0;
      write_data_q    <= '0;
      read_q          <= 1'b0;
      write_q         <= 1'b0;
      spurious_q      <= 1'b0;
    end else begin
      if (master_ifc_ready_i && (state_q != S_REQ)) begin
        spurious_q <= 1'b1;
      end
      if (pop) begin
        state_q      <= S_REQ;
        cnt_q        <= '0;
        write_q      <= head[ENT_W-1];
        read_q       <= ~head[ENT_W-1];
        address_q    <= head[ENT_W-2 -: ADDR_W];
        write_data_q <= head[DATA_W-1:0];
      end
      case (state_q)
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A ready arriving on the last allowed cycle still completes normally.
          if (master_ifc_ready_i) begin
            state_q         <= S_RSP;
            read_q          <= 1'b0;
            write_q         <= 1'b0;
            rsp_valid_q     <= 1'b1;
            rsp_read_data_q <= read_q ? master_ifc_read_data_i : '0;
            rsp_error_q     <= master_ifc_error_i;
            rsp_timeout_q   <= 1'b0;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            state_q         <= S_RSP;
            read_q          <= 1'b0;
            write_q         <= 1'b0;
            rsp_valid_q     <= 1'b1;
            rsp_read_data_q <= '0;
            rsp_error_q     <= 1'b1;
            rsp_timeout_q   <= 1'b1;
          end
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            if (!pop) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid_o             = rsp_valid_q;
  assign rsp_read_data_o         = rsp_read_data_q;
  assign rsp_error_o             = rsp_error_q;
  assign rsp_timeout_o           = rsp_timeout_q;
  assign master_ifc_address_o    = address_q;
  assign master_ifc_write_data_o = write_data_q;
  assign master_ifc_read_o       = read_q;
  assign master_ifc_write_o      = write_q;
  assign busy_o                  = !fifo_empty || (state_q != S_IDLE);
  assign spurious_ready_o        = spurious_q;

endmodule
`default_nettype wire
